// File: rtl/instruction_decode_stage_if.sv
// rtl/instruction_decode_stage_if.sv - fetch/execute side bundle of the MIPS decode stage
interface instruction_decode_stage_if #(
    parameter int DATA_W      = 32,
    parameter int PC_W        = 32,
    parameter int STALL_CNT_W = 16
);
    logic [31:0]            i_instr;
    logic [PC_W-1:0]        i_pc;
    logic                   i_valid;
    logic                   o_ready;
    logic                   o_valid;
    logic                   i_ex_ready;
    logic                   i_flush;
    logic [PC_W-1:0]        o_pc;
    logic [5:0]             o_funct;
    logic [4:0]             o_rs;
    logic [4:0]             o_rt;
    logic [4:0]             o_rd;
    logic [4:0]             o_sa;
    logic [DATA_W-1:0]      o_imm;
    logic [25:0]            o_addr_offset;
    logic [4:0]             o_link_reg;
    logic [4:0]             o_addr_reg;
    logic                   o_flg_pc_modify;
    logic                   o_flg_link_ret;
    logic                   o_flg_cmp;
    logic                   o_flg_equal;
    logic                   o_flg_inmediate;
    logic                   o_flg_mem_op;
    logic                   o_flg_mem_type;
    logic                   o_flg_unsign;
    logic                   o_flg_illegal;
    logic [1:0]             o_flg_addr_type;
    logic [1:0]             o_flg_mem_size;
    logic [STALL_CNT_W-1:0] o_stall_cnt;

    modport master (
        output i_instr, i_pc, i_valid, i_ex_ready, i_flush,
        input  o_ready, o_valid, o_pc, o_funct, o_rs, o_rt, o_rd, o_sa, o_imm,
               o_addr_offset, o_link_reg, o_addr_reg, o_flg_pc_modify, o_flg_link_ret,
               o_flg_cmp, o_flg_equal, o_flg_inmediate, o_flg_mem_op, o_flg_mem_type,
               o_flg_unsign, o_flg_illegal, o_flg_addr_type, o_flg_mem_size, o_stall_cnt
    );

    modport slave (
        input  i_instr, i_pc, i_valid, i_ex_ready, i_flush,
        output o_ready, o_valid, o_pc, o_funct, o_rs, o_rt, o_rd, o_sa, o_imm,
               o_addr_offset, o_link_reg, o_addr_reg, o_flg_pc_modify, o_flg_link_ret,
               o_flg_cmp, o_flg_equal, o_flg_inmediate, o_flg_mem_op, o_flg_mem_type,
               o_flg_unsign, o_flg_illegal, o_flg_addr_type, o_flg_mem_size, o_stall_cnt
    );
endinterface

// File: rtl/instruction_decode_stage.sv
// rtl/instruction_decode_stage.sv - MIPS decode into the ID/EX register with load-use bubble and flush
module instruction_decode_stage #(
    parameter int DATA_W      = 32,
    parameter int PC_W        = 32,
    parameter int LINK_REG    = 31,
    parameter int STALL_CNT_W = 16
) (
    input logic                       i_clk,
    input logic                       i_rst_n,
    instruction_decode_stage_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    localparam logic [1:0] ADDR_REG    = 2'b00;
    localparam logic [1:0] ADDR_REGION = 2'b01;
    localparam logic [1:0] ADDR_PCREL  = 2'b10;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [5:0]        funct;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        sa;
        logic [DATA_W-1:0] imm;
        logic [25:0]       addr_offset;
        logic [4:0]        link_reg;
        logic [4:0]        addr_reg;
        logic              pc_modify;
        logic              link_ret;
        logic              cmp;
        logic              equal;
        logic              inmediate;
        logic              mem_op;
        logic              mem_type;
        logic              unsign;
        logic              illegal;
        logic [1:0]        addr_type;
        logic [1:0]        mem_size;
    } idex_t;

    idex_t                  dec;
    idex_t                  q;
    logic                   valid_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic [5:0]        op;
    logic [5:0]        f_funct;
    logic [4:0]        f_rs;
    logic [4:0]        f_rt;
    logic [4:0]        f_rd;
    logic [4:0]        f_sa;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_lui;
    logic              is_load;
    logic              is_store;

    assign op       = bus.i_instr[31:26];
    assign f_rs     = bus.i_instr[25:21];
    assign f_rt     = bus.i_instr[20:16];
    assign f_rd     = bus.i_instr[15:11];
    assign f_sa     = bus.i_instr[10:6];
    assign f_funct  = bus.i_instr[5:0];
    assign imm16    = bus.i_instr[15:0];
    assign imm_sext = DATA_W'($signed(imm16));
    assign imm_zext = DATA_W'(imm16);
    assign imm_lui  = DATA_W'($signed({imm16, 16'h0000}));
    assign is_load  = op inside {6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101};
    assign is_store = op inside {6'b101000, 6'b101001, 6'b101011};

    always_comb begin
        dec    = '0;
        dec.pc = bus.i_pc;
        if (op == OP_RTYPE) begin
            dec.funct = f_funct;
            dec.rs    = f_rs;
            dec.rt    = f_rt;
            dec.rd    = f_rd;
            dec.sa    = f_sa;
            dec.imm   = imm_sext;
            if (f_funct == FN_JR || f_funct == FN_JALR) begin
                dec.pc_modify = 1'b1;
                dec.addr_reg  = f_rs;
                dec.addr_type = ADDR_REG;
            end
            if (f_funct == FN_JALR) begin
                dec.link_ret = 1'b1;
                dec.link_reg = f_rd;
            end
        end else if (op == OP_J || op == OP_JAL) begin
            dec.imm         = imm_sext;
            dec.pc_modify   = 1'b1;
            dec.addr_type   = ADDR_REGION;
            dec.addr_offset = bus.i_instr[25:0];
            if (op == OP_JAL) begin
                dec.link_ret = 1'b1;
                dec.link_reg = 5'(LINK_REG);
            end
        end else if (op == OP_BEQ || op == OP_BNE) begin
            dec.rs          = f_rs;
            dec.rt          = f_rt;
            dec.imm         = imm_sext;
            dec.pc_modify   = 1'b1;
            dec.cmp         = 1'b1;
            dec.equal       = (op == OP_BEQ);
            dec.addr_type   = ADDR_PCREL;
            dec.addr_offset = 26'($signed(imm16));
        end else if (op[5:3] == 3'b001) begin
            dec.funct     = {3'b000, op[2:0]};
            dec.rs        = f_rs;
            dec.rt        = f_rt;
            dec.inmediate = 1'b1;
            // logical ops zero-extend, LUI places the field in the upper half
            case (op[2:0])
                3'b100, 3'b101, 3'b110: dec.imm = imm_zext;
                3'b111:                 dec.imm = imm_lui;
                default:                dec.imm = imm_sext;
            endcase
        end else if (is_load || is_store) begin
            dec.funct     = {3'b000, op[2:0]};
            dec.rs        = f_rs;
            dec.rt        = f_rt;
            dec.imm       = imm_sext;
            dec.inmediate = 1'b1;
            dec.mem_op    = 1'b1;
            dec.mem_type  = is_store;
            dec.mem_size  = op[1:0];
            dec.unsign    = is_load & op[2];
        end else begin
            dec.illegal = 1'b1;
        end
    end

    logic ld_held;
    logic reads_rs;
    logic reads_rt;
    logic hazard;
    logic ready;

    // a held load whose destination the incoming instruction sources must drain first
    assign ld_held  = valid_q && q.mem_op && !q.mem_type && (q.rt != 5'd0);
    assign reads_rs = (op != OP_J) && (op != OP_JAL);
    assign reads_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || is_store;
    assign hazard   = ld_held && ((reads_rs && (f_rs == q.rt)) || (reads_rt && (f_rt == q.rt)));
    assign ready    = !bus.i_flush && !hazard && (!valid_q || bus.i_ex_ready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q     <= 1'b0;
            q           <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (bus.i_valid && hazard && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (bus.i_flush) begin
                valid_q <= 1'b0;
            end else if (bus.i_valid && ready) begin
                valid_q <= 1'b1;
                q       <= dec;
            end else if (bus.i_ex_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.o_ready         = ready;
    assign bus.o_valid         = valid_q;
    assign bus.o_pc            = q.pc;
    assign bus.o_funct         = q.funct;
    assign bus.o_rs            = q.rs;
    assign bus.o_rt            = q.rt;
    assign bus.o_rd            = q.rd;
    assign bus.o_sa            = q.sa;
    assign bus.o_imm           = q.imm;
    assign bus.o_addr_offset   = q.addr_offset;
    assign bus.o_link_reg      = q.link_reg;
    assign bus.o_addr_reg      = q.addr_reg;
    assign bus.o_flg_pc_modify = q.pc_modify;
    assign bus.o_flg_link_ret  = q.link_ret;
    assign bus.o_flg_cmp       = q.cmp;
    assign bus.o_flg_equal     = q.equal;
    assign bus.o_flg_inmediate = q.inmediate;
    assign bus.o_flg_mem_op    = q.mem_op;
    assign bus.o_flg_mem_type  = q.mem_type;
    assign bus.o_flg_unsign    = q.unsign;
    assign bus.o_flg_illegal   = q.illegal;
    assign bus.o_flg_addr_type = q.addr_type;
    assign bus.o_flg_mem_size  = q.mem_size;
    assign bus.o_stall_cnt     = stall_cnt_q;
endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb/tb_instruction_decode_stage.sv - self-checking bench for instruction_decode_stage
`timescale 1ns/1ps
module tb_instruction_decode_stage;
    localparam int DW      = 64;
    localparam int PW      = 32;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam logic [31:0] ADDU  = 32'h00221821; // addu $3,$1,$2
    localparam logic [31:0] ORI   = 32'h3408FFFF; // ori  $t0,$0,0xffff
    localparam logic [31:0] LUI   = 32'h3C098000; // lui  $t1,0x8000
    localparam logic [31:0] LW    = 32'h8E090000; // lw   $t1,0($s0)
    localparam logic [31:0] ADD   = 32'h012B5020; // add  $t2,$t1,$t3
    localparam logic [31:0] LW0   = 32'h8E000000; // lw   $0,0($s0)
    localparam logic [31:0] ADD0  = 32'h000B5020; // add  $t2,$0,$t3
    localparam logic [31:0] BEQ   = 32'h1022FFFC; // beq  $1,$2,-4
    localparam logic [31:0] JAL   = 32'h0C000100;
    localparam logic [31:0] ILL3F = 32'hFC000000;
    localparam logic [31:0] LWL   = 32'h88090000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_decode_stage_if #(.DATA_W(DW), .PC_W(PW), .STALL_CNT_W(CW)) bus ();

    instruction_decode_stage #(
        .DATA_W(DW), .PC_W(PW), .LINK_REG(31), .STALL_CNT_W(CW)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [5:0]  funct;
        logic [4:0]  rs, rt, rd, sa;
        logic [63:0] imm;
        logic [25:0] off;
        logic [4:0]  link, areg;
        logic        pcmod, lret, cmp, eq, immf, mem, mtype, uns, ill;
        logic [1:0]  atype, msize;
    } dec_t;

    function automatic bit is_ld(input logic [5:0] op);
        return op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25;
    endfunction

    function automatic bit is_st(input logic [5:0] op);
        return op == 6'h28 || op == 6'h29 || op == 6'h2B;
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t        d;
        logic [5:0]  op;
        logic [63:0] sx;
        d  = '0;
        op = w[31:26];
        sx = {{48{w[15]}}, w[15:0]};
        if (op == 6'd0) begin
            d.funct = w[5:0]; d.rs = w[25:21]; d.rt = w[20:16]; d.rd = w[15:11]; d.sa = w[10:6];
            d.imm = sx;
            if (w[5:0] == 6'd8 || w[5:0] == 6'd9) begin d.pcmod = 1; d.areg = w[25:21]; end
            if (w[5:0] == 6'd9) begin d.lret = 1; d.link = w[15:11]; end
        end else if (op == 6'd2 || op == 6'd3) begin
            d.imm = sx; d.pcmod = 1; d.atype = 2'b01; d.off = w[25:0];
            if (op == 6'd3) begin d.lret = 1; d.link = 5'd31; end
        end else if (op == 6'd4 || op == 6'd5) begin
            d.rs = w[25:21]; d.rt = w[20:16]; d.imm = sx; d.pcmod = 1; d.cmp = 1;
            d.eq = (op == 6'd4); d.atype = 2'b10; d.off = {{10{w[15]}}, w[15:0]};
        end else if (op >= 6'h08 && op <= 6'h0F) begin
            d.funct = {3'b0, op[2:0]}; d.rs = w[25:21]; d.rt = w[20:16]; d.immf = 1;
            if (op == 6'h0C || op == 6'h0D || op == 6'h0E) d.imm = {48'h0, w[15:0]};
            else if (op == 6'h0F) d.imm = {{32{w[15]}}, w[15:0], 16'h0000};
            else d.imm = sx;
        end else if (is_ld(op) || is_st(op)) begin
            d.funct = {3'b0, op[2:0]}; d.rs = w[25:21]; d.rt = w[20:16]; d.immf = 1; d.imm = sx;
            d.mem = 1; d.mtype = is_st(op); d.uns = is_ld(op) && op[2];
            d.msize = (op[1:0] == 2'b00) ? 2'b00 : (op[1:0] == 2'b01) ? 2'b01 : 2'b11;
        end else begin
            d.ill = 1;
        end
        return d;
    endfunction

    // model: the instruction word and PC the ID/EX register should be holding
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    int          m_cnt;

    function automatic bit m_hazard(input logic [31:0] w);
        logic [4:0] dst;
        logic [5:0] op;
        bit         use_rs, use_rt;
        dst    = m_instr[20:16];
        op     = w[31:26];
        use_rs = !(op == 6'd2 || op == 6'd3);
        use_rt = op == 6'd0 || op == 6'd4 || op == 6'd5 || is_st(op);
        return m_valid && is_ld(m_instr[31:26]) && dst != 5'd0 &&
               ((use_rs && w[25:21] == dst) || (use_rt && w[20:16] == dst));
    endfunction

    function automatic bit exp_ready();
        if (bus.i_flush) return 0;
        if (m_hazard(bus.i_instr)) return 0;
        return !m_valid || bus.i_ex_ready;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_instr <= '0;
            m_pc    <= '0;
            m_cnt   <= 0;
        end else begin
            if (bus.i_valid && m_hazard(bus.i_instr) && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
            m_valid <= !bus.i_flush && ((bus.i_valid && exp_ready()) || (m_valid && !bus.i_ex_ready));
            if (bus.i_valid && exp_ready()) begin
                m_instr <= bus.i_instr;
                m_pc    <= bus.i_pc;
            end
        end
    end

    task automatic check_payload(input dec_t e);
        chk("pc", bus.o_pc, m_pc);
        chk("funct", bus.o_funct, e.funct);
        chk("rs", bus.o_rs, e.rs);
        chk("rt", bus.o_rt, e.rt);
        chk("rd", bus.o_rd, e.rd);
        chk("sa", bus.o_sa, e.sa);
        chk("imm", bus.o_imm, e.imm);
        chk("addr_offset", bus.o_addr_offset, e.off);
        chk("link_reg", bus.o_link_reg, e.link);
        chk("addr_reg", bus.o_addr_reg, e.areg);
        chk("pc_modify", bus.o_flg_pc_modify, e.pcmod);
        chk("link_ret", bus.o_flg_link_ret, e.lret);
        chk("cmp", bus.o_flg_cmp, e.cmp);
        chk("equal", bus.o_flg_equal, e.eq);
        chk("inmediate", bus.o_flg_inmediate, e.immf);
        chk("mem_op", bus.o_flg_mem_op, e.mem);
        chk("mem_type", bus.o_flg_mem_type, e.mtype);
        chk("unsign", bus.o_flg_unsign, e.uns);
        chk("illegal", bus.o_flg_illegal, e.ill);
        chk("addr_type", bus.o_flg_addr_type, e.atype);
        chk("mem_size", bus.o_flg_mem_size, e.msize);
    endtask

    always @(negedge clk) begin
        chk("ready", bus.o_ready, exp_ready());
        chk("valid", bus.o_valid, m_valid);
        chk("stall_cnt", bus.o_stall_cnt, m_cnt);
        if (m_valid) check_payload(ref_decode(m_instr));
    end

    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic drive(input logic [31:0] w, input logic v, input logic er, input logic fl);
        bus.i_instr    = w;
        bus.i_valid    = v;
        bus.i_ex_ready = er;
        bus.i_flush    = fl;
        bus.i_pc       = pc_ctr;
        pc_ctr         = pc_ctr + 32'd4;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_instr = '0; bus.i_valid = 0; bus.i_ex_ready = 0; bus.i_flush = 0; bus.i_pc = '0;
        #2;
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_stall", bus.o_stall_cnt, 0);
        chk("rst_imm", bus.o_imm, 0);
        chk("rst_pc", bus.o_pc, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        chk("rst_ready", bus.o_ready, 1);

        // streaming with execute always ready
        drive(ADDU, 1, 1, 0); tick();
        chk("addu_valid", bus.o_valid, 1);
        chk("addu_funct", bus.o_funct, 6'h21);
        drive(ORI, 1, 1, 0); tick();
        chk("ori_imm", bus.o_imm, 64'h0000_0000_0000_FFFF);
        drive(LUI, 1, 1, 0); tick();
        chk("lui_valid", bus.o_valid, 1);
        chk("lui_imm", bus.o_imm, 64'hFFFF_FFFF_8000_0000);
        drive(0, 0, 1, 0); tick();
        chk("drain_valid", bus.o_valid, 0);

        // load-use bubble
        drive(LW, 1, 1, 0); tick();
        drive(ADD, 1, 1, 0);
        chk("lu_ready0", bus.o_ready, 0);
        tick();
        chk("lu_bubble", bus.o_valid, 0);
        chk("lu_stall1", bus.o_stall_cnt, 1);
        chk("lu_ready1", bus.o_ready, 1);
        tick();
        chk("lu_add_valid", bus.o_valid, 1);
        chk("lu_add_rd", bus.o_rd, 10);

        // load to $0 never stalls
        drive(LW0, 1, 1, 0); tick();
        drive(ADD0, 1, 1, 0);
        chk("lw0_ready", bus.o_ready, 1);
        tick();
        chk("lw0_valid", bus.o_valid, 1);
        chk("lw0_stall", bus.o_stall_cnt, 1);

        // control flow
        drive(BEQ, 1, 1, 0); tick();
        chk("beq_off", bus.o_addr_offset, 26'h3FFFFFC);
        chk("beq_cmp", bus.o_flg_cmp, 1);
        chk("beq_eq", bus.o_flg_equal, 1);
        chk("beq_atype", bus.o_flg_addr_type, 2'b10);
        drive(JAL, 1, 1, 0); tick();
        chk("jal_link", bus.o_link_reg, 31);
        chk("jal_lret", bus.o_flg_link_ret, 1);

        // flush refuses the fetch word, accepts it next cycle
        drive(ADDU, 1, 1, 0); tick();
        drive(ORI, 1, 1, 1);
        chk("fl_ready", bus.o_ready, 0);
        tick();
        chk("fl_valid", bus.o_valid, 0);
        drive(ORI, 1, 1, 0); tick();
        chk("fl_acc", bus.o_valid, 1);
        chk("fl_acc_imm", bus.o_imm, 64'hFFFF);

        // execute back-pressure for three cycles
        drive(ADDU, 1, 1, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(ORI, 1, 0, 0);
            chk("hold_ready", bus.o_ready, 0);
            tick();
            chk("hold_funct", bus.o_funct, 6'h21);
        end
        drive(ORI, 1, 1, 0);
        chk("rel_ready", bus.o_ready, 1);
        tick();
        chk("rel_funct", bus.o_funct, 6'h05);

        // illegal opcodes still issue
        drive(ILL3F, 1, 1, 0); tick();
        chk("ill3f_flag", bus.o_flg_illegal, 1);
        drive(LWL, 1, 1, 0); tick();
        chk("lwl_flag", bus.o_flg_illegal, 1);
        chk("lwl_mem", bus.o_flg_mem_op, 0);

        // stall counter saturation under a held hazard
        drive(LW, 1, 1, 0); tick();
        for (int i = 0; i < 20; i++) begin
            drive(ADD, 1, 0, 0); tick();
        end
        chk("sat_cnt", bus.o_stall_cnt, CNT_MAX);
        drive(ADD, 1, 1, 0); tick();
        chk("sat_bubble", bus.o_valid, 0);
        tick();
        chk("sat_add", bus.o_funct, 6'h20);

        // reset in the middle of a hazard
        drive(LW, 1, 1, 0); tick();
        drive(ADD, 1, 1, 0);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", bus.o_valid, 0);
        chk("mrst_imm", bus.o_imm, 0);
        chk("mrst_funct", bus.o_funct, 0);
        chk("mrst_pc", bus.o_pc, 0);
        chk("mrst_rt", bus.o_rt, 0);
        chk("mrst_stall", bus.o_stall_cnt, 0);
        chk("mrst_ready", bus.o_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        chk("mrst_acc", bus.o_valid, 1);
        chk("mrst_acc_funct", bus.o_funct, 6'h20);

        drive(0, 0, 1, 0); tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_decode_stage.md
# instruction_decode_stage

Registered MIPS decode stage between fetch and execute. Decodes one 32-bit instruction per cycle into the operand, immediate, control-flow and memory flag bundle, and holds it in the ID/EX pipeline register with a valid/ready handshake on both sides. Adds hardware load-use bubble insertion, flush on taken branch, illegal-opcode flagging, width-parametrised immediate extension, and a saturating stall counter.

## Interface
- DATA_W, 32: datapath width; o_imm is extended to this width (32 or 64)
- PC_W, 32: width of i_pc/o_pc
- LINK_REG, 31: link register index written by JAL
- STALL_CNT_W, 16: width of o_stall_cnt
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_instr  in  32  instruction from fetch
- i_pc  in  PC_W  PC of i_instr
- i_valid  in  1  i_instr/i_pc valid
- o_ready  out  1  stage accepts i_instr this cycle (combinational)
- o_valid  out  1  ID/EX register holds a valid instruction
- i_ex_ready  in  1  execute consumes the ID/EX register this cycle
- i_flush  in  1  taken branch/jump: discard the ID/EX register and refuse input
- o_pc  out  PC_W  registered PC
- o_funct  out  6  R-type funct, or {3'b0, opcode[2:0]} for arith-imm/load/store
- o_rs, o_rt, o_rd, o_sa  out  5 each  register fields
- o_imm  out  DATA_W  extended immediate
- o_addr_offset  out  26  J/JAL target field, or branch offset sign-extended to 26 bits
- o_link_reg, o_addr_reg  out  5 each  link destination / jump-register source
- o_flg_pc_modify, o_flg_link_ret, o_flg_cmp, o_flg_equal, o_flg_inmediate, o_flg_mem_op, o_flg_mem_type, o_flg_unsign, o_flg_illegal  out  1 each
- o_flg_addr_type  out  2  00 register, 01 26-bit region, 10 PC-relative
- o_flg_mem_size  out  2  00 byte, 01 half, 11 word
- o_stall_cnt  out  STALL_CNT_W  saturating count of load-use stall cycles

## Operation
- Decode map: R-type, JR, JALR, J, JAL, BEQ, BNE, 001xxx arith-imm, loads LB/LH/LW/LBU/LHU (100000/100001/100011/100100/100101), stores SB/SH/SW (101000/101001/101011).
- JR/JALR: o_addr_reg = rs, o_flg_addr_type = 00. JALR: o_link_reg = rd. JAL: o_link_reg = LINK_REG.
- All other opcodes/loads/stores set o_flg_illegal = 1, all other flags 0, register fields 0. The instruction still issues so EX can trap.
- Immediate: ANDI/ORI/XORI are zero-extended. LUI gives imm << 16, sign-extended from bit 31 to DATA_W. All others are sign-extended.
- Branch offset: sign-extended 16 to 26 bits.
- Load o_flg_unsign = opcode[2]. Stores unsign 0.
- Accept: o_ready = !i_flush && !hazard && (!o_valid || i_ex_ready). On i_valid && o_ready, the ID/EX register loads the decode and o_valid becomes 1.
- Drain: o_valid && i_ex_ready without accept sets o_valid to 0.
- Hold: o_valid && !i_ex_ready keeps all outputs stable.
- Hazard is true when all hold:
  - o_valid
  - ID/EX holds a load (o_flg_mem_op && !o_flg_mem_type)
  - o_rt != 0
  - incoming reads it: rs == o_rt for all non-J/JAL, or rt == o_rt for R-type/BEQ/BNE/store
- While hazard holds, the load drains on i_ex_ready, leaving exactly one bubble (o_valid = 0). The consumer is accepted the following cycle.
- Stall counter: increments each cycle with i_valid && hazard, saturating at all-ones.
- Flush: i_flush clears o_valid next edge. It takes priority over accept and hold, and the stall counter is unaffected.
- Bubble/flush: only o_valid clears; payload registers may keep stale values.

## Timing
- Decode-to-output latency is 1 cycle. Throughput is 1/cycle absent hazards.
- Reset (async assert, sync-safe deassert):
  - o_valid, all flags, fields, o_imm, o_pc, o_addr_offset and o_stall_cnt are 0.
  - o_ready is 1 in the first cycle after reset.
- o_ready depends combinationally on i_instr, i_ex_ready and i_flush only; there is no path from i_valid.
- Simultaneous accept and drain: new instruction replaces old in the same edge, o_valid stays 1.
- Reset mid-hazard: the pending load is lost and the hazard clears.

## Test plan
- Streaming ADDU, ORI $t0,$0,0xFFFF, LUI 0x8000 with DATA_W=64 and i_ex_ready=1:
  - o_valid is 1 every cycle.
  - ORI o_imm = 0x000000000000FFFF.
  - LUI o_imm = 0xFFFFFFFF80000000.
- LW $t1,0($s0) then ADD $t2,$t1,$t3: one cycle with o_valid=0 between them, o_ready=0 for exactly one cycle, o_stall_cnt=1. Repeat with LW to $0: no bubble.
- BEQ offset 0xFFFC: o_addr_offset=0x3FFFFFC, o_flg_cmp=o_flg_equal=1, o_flg_addr_type=10. JAL: o_link_reg=31, o_flg_link_ret=1.
- Assert i_flush while o_valid=1 and i_valid=1: o_valid=0 next cycle, the fetch instruction is not accepted, and it is accepted the following cycle.
- i_ex_ready=0 for 3 cycles with valid output: outputs stable, o_ready=0. Release: next instruction accepted the same cycle.
- Opcode 0x3F and 100010 (LWL): o_flg_illegal=1, o_flg_mem_op=0. Reset asserted mid-stream: all outputs 0 immediately.
